// File: rtl/alu_result_tx_pkg.sv
// Shared types and constants for the ALU result serial transmitter.
// ALU_TX_PARITY_EN adds an even-parity bit to every frame.
package alu_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   FLAG_ZERO  = 0;
  localparam int   FLAG_CARRY = 1;
  localparam int   FLAG_OVF   = 2;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   NUM_BYTES  = 2;
  localparam int   BYTE_W     = 8;

  function automatic logic [BYTE_W-1:0] pack_flags(
    input logic z,
    input logic c,
    input logic o
  );
    logic [BYTE_W-1:0] f;
    f             = '0;
    f[FLAG_ZERO]  = z;
    f[FLAG_CARRY] = c;
    f[FLAG_OVF]   = o;
    return f;
  endfunction

endpackage

// File: rtl/alu_result_tx_if.sv
// Request/status bundle between the ALU side and the result transmitter.
// ALU_TX_PARITY_EN does not change this bundle.
interface alu_result_tx_if;
  import alu_tx_pkg::*;

  logic              start;
  logic [BYTE_W-1:0] result;
  logic              zero;
  logic              carry;
  logic              overflow;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output start, result, zero, carry, overflow,
    input  tx, busy, done
  );

  modport slave (
    input  start, result, zero, carry, overflow,
    output tx, busy, done
  );

endinterface

// File: rtl/alu_result_tx_baud.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles, held at 0 by i_clr.
// Unaffected by ALU_TX_PARITY_EN.
module alu_tx_baud
  import alu_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last && !i_clr;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_tx.sv
// Sends the latched ALU result then the flag byte as two serial frames.
// Define ALU_TX_PARITY_EN for an even-parity bit before each stop bit.
module alu_result_tx
  import alu_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8
) (
  input logic           clk,
  input logic           rst,
  alu_result_tx_if.slave bus
);

  if (DATA_W != 8) begin : g_bad_width
    $error("alu_result_tx: DATA_W must be 8");
  end
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("alu_result_tx: CLKS_PER_BIT out of range");
  end

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_STOP   = STOP;
`ifdef ALU_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
`endif
  localparam logic LAST_BYTE = 1'(NUM_BYTES - 1);

  logic [2:0]        r_state;
  logic [BYTE_W-1:0] r_byte0;
  logic [BYTE_W-1:0] r_byte1;
  logic [BYTE_W-1:0] r_shift;
  logic [2:0]        r_bit;
  logic              r_byte_idx;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic              w_tick;
  logic              w_clr;
  logic [BYTE_W-1:0] w_cur;

  assign w_clr = (r_state == S_IDLE);
  assign w_cur = r_byte_idx ? r_byte1 : r_byte0;

  alu_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte0    <= '0;
      r_byte1    <= '0;
      r_shift    <= '0;
      r_bit      <= '0;
      r_byte_idx <= 1'b0;
      r_tx       <= IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_byte0    <= bus.result;
            r_byte1    <= pack_flags(bus.zero,
                                     bus.carry,
                                     bus.overflow);
            r_byte_idx <= 1'b0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_tx    <= w_cur[0];
            r_shift <= w_cur >> 1;
            r_bit   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit == 3'd7) begin
`ifdef ALU_TX_PARITY_EN
              r_tx    <= ^w_cur;
              r_state <= S_PARITY;
`else
              r_tx    <= IDLE_LEVEL;
              r_state <= S_STOP;
`endif
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 1'b1;
            end
          end
        end
`ifdef ALU_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_tx    <= IDLE_LEVEL;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            if (r_byte_idx == LAST_BYTE) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              // back-to-back frames: no idle gap
              r_tx       <= 1'b0;
              r_byte_idx <= 1'b1;
              r_state    <= S_START;
            end
          end
        end
        default: begin
          r_tx    <= IDLE_LEVEL;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx with a frame-level reference model.
// Define ALU_TX_PARITY_EN to check the parity build.
module tb_alu_result_tx;
  import alu_tx_pkg::*;

  localparam int CPB = 4;
`ifdef ALU_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int NB       = 2 * FB;
  localparam int BUSY_CYC = NB * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_result_tx_if bus ();

  alu_result_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_bad    = 0;
  int done_cnt = 0;
  logic cap[$];

  // whole two-byte line waveform, one entry per bit period
  function automatic logic [0:NB-1] frame(
    input logic [7:0] b0,
    input logic [7:0] b1
  );
    logic [0:NB-1] f;
    logic [7:0]    b;
    int            p;
    f = '1;
    p = 0;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? b0 : b1;
      f[p] = 1'b0; p++;
      for (int i = 0; i < 8; i++) begin
        f[p] = b[i]; p++;
      end
`ifdef ALU_TX_PARITY_EN
      f[p] = ^b; p++;
`endif
      f[p] = 1'b1; p++;
    end
    return f;
  endfunction

  int            m_pos  = -1;
  logic          m_done = 1'b0;
  logic          m_live = 1'b0;
  logic [0:NB-1] m_bits = '1;
  logic          e_busy;
  logic          e_tx;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_pos  = -1;
      m_live = 1'b1;
    end else if (m_pos < 0) begin
      if (bus.start) begin
        m_bits = frame(bus.result,
                       {5'b0, bus.overflow, bus.carry, bus.zero});
        m_pos  = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == BUSY_CYC) begin
        m_pos  = -1;
        m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      e_busy = (m_pos >= 0);
      e_tx   = e_busy ? m_bits[m_pos / CPB] : 1'b1;
      n_vec++;
      if ({bus.tx, bus.busy, bus.done} !== {e_tx, e_busy, m_done}) begin
        n_bad++;
        $display("FAIL line t=%0t: tx/busy/done got %b%b%b want %b%b%b",
                 $time, bus.tx, bus.busy, bus.done,
                 e_tx, e_busy, m_done);
      end
      if (bus.busy) cap.push_back(bus.tx);
      if (bus.done) done_cnt++;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  function automatic logic rx_bit(input int slot);
    int idx;
    idx = slot * CPB + CPB / 2;
    if (idx < cap.size()) return cap[idx];
    return 1'b0;
  endfunction

  function automatic logic [7:0] rx_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = rx_bit(k * FB + 1 + i);
    return b;
  endfunction

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < BUSY_CYC + 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic pulse(input logic [7:0] r,
                       input logic z, input logic c, input logic o);
    bus.result   = r;
    bus.zero     = z;
    bus.carry    = c;
    bus.overflow = o;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_bytes(input string nm,
                             input logic [7:0] e0,
                             input logic [7:0] e1);
    chk({nm, "_busy_len"}, cap.size(), BUSY_CYC);
    chk({nm, "_byte0"}, int'(rx_byte(0)), int'(e0));
    chk({nm, "_byte1"}, int'(rx_byte(1)), int'(e1));
`ifdef ALU_TX_PARITY_EN
    chk({nm, "_par0"}, int'(rx_bit(9)), int'(^e0));
    chk({nm, "_par1"}, int'(rx_bit(FB + 9)), int'(^e1));
`endif
  endtask

  task automatic xfer(input string nm, input logic [7:0] r,
                      input logic z, input logic c, input logic o,
                      input logic chg,
                      input logic [7:0] e0, input logic [7:0] e1);
    cap.delete();
    done_cnt = 0;
    pulse(r, z, c, o);
    if (chg) begin
      bus.result   = 8'h00;
      bus.zero     = 1'b1;
      bus.carry    = 1'b1;
      bus.overflow = 1'b1;
    end
    wait_done(nm);
    repeat (3) @(negedge clk);
    check_bytes(nm, e0, e1);
    chk({nm, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.result   = 8'h00;
    bus.zero     = 1'b0;
    bus.carry    = 1'b0;
    bus.overflow = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out", int'({bus.tx, bus.busy, bus.done}), 3'b100);
    rst = 1'b0;

`ifdef ALU_TX_PARITY_EN
    chk("model_frame", int'(frame(8'hA5, 8'h02)),
        22'b0_10100101_0_1_0_01000000_1_1);
`else
    chk("model_frame", int'(frame(8'hA5, 8'h02)),
        20'b0_10100101_1_0_01000000_1);
`endif

    done_cnt = 0;
    repeat (20) @(negedge clk);
    chk("idle_done", done_cnt, 0);
    chk("idle_tx", int'(bus.tx), 1);

    xfer("a5", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h02);
    xfer("chg", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h02);

    // starts while busy are dropped; start in the done cycle is taken
    cap.delete();
    done_cnt = 0;
    pulse(8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    bus.result = 8'h11;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (39) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("repulse");
    chk("repulse_len", cap.size(), BUSY_CYC);
    chk("repulse_b0", int'(rx_byte(0)), 8'hA5);
    cap.delete();
    pulse(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("restart_busy", int'(bus.busy), 1);
    chk("restart_tx", int'(bus.tx), 0);
    wait_done("restart");
    repeat (3) @(negedge clk);
    check_bytes("restart", 8'hFF, 8'h01);
    chk("restart_done_cnt", done_cnt, 2);

    // reset in the middle of a transfer
    cap.delete();
    done_cnt = 0;
    pulse(8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (28) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", int'({bus.tx, bus.busy, bus.done}), 3'b100);
    rst = 1'b0;
    repeat (BUSY_CYC) @(negedge clk);
    chk("midrst_done", done_cnt, 0);
    xfer("post_rst", 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h04);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
